// File: rtl/victim_swap_ctrl.sv
// victim_swap_ctrl: L1 miss controller that swaps the evicted line into the victim cache,
// then fills from the victim cache on a hit or from pmem on a victim miss.
module victim_swap_ctrl #(
    parameter int WIDTH = 256,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             miss_req_i,
    input  logic [31:0]      miss_addr_i,
    input  logic             evict_dirty_i,
    input  logic [WIDTH-1:0] evict_data_i,
    output logic             busy_o,
    output logic             miss_resp_o,
    output logic [WIDTH-1:0] fill_data_o,
    output logic             fill_from_vc_o,
    output logic             vc_request_o,
    output logic [31:0]      vc_address_o,
    output logic             vc_is_dirty_o,
    output logic [WIDTH-1:0] vc_evicted_o,
    input  logic             vc_resp_i,
    input  logic             vc_found_i,
    input  logic [WIDTH-1:0] vc_dataout_i,
    output logic             pmem_read_o,
    output logic [31:0]      pmem_address_o,
    input  logic [WIDTH-1:0] pmem_rdata_i,
    input  logic             pmem_resp_i,
    output logic [CNT_W-1:0] vc_hit_cnt_o,
    output logic [CNT_W-1:0] vc_miss_cnt_o
);
    typedef enum logic [1:0] {IDLE, VC_REQ, MEM_READ, FILL} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d, miss_resp_q, miss_resp_d, fill_vc_q, fill_vc_d;
    logic               vc_req_q, vc_req_d, vc_dirty_q, vc_dirty_d, pmem_read_q, pmem_read_d;
    logic [WIDTH-1:0]   fill_q, fill_d, evicted_q, evicted_d;
    logic [31:0]        vc_addr_q, vc_addr_d, pmem_addr_q, pmem_addr_d;
    logic [CNT_W-1:0]   hit_q, hit_d, miss_q, miss_d;

    always_comb begin
        state_d     = state_q;
        miss_resp_d = 1'b0;
        fill_vc_d   = fill_vc_q;
        vc_req_d    = vc_req_q;
        vc_dirty_d  = vc_dirty_q;
        pmem_read_d = pmem_read_q;
        fill_d      = fill_q;
        evicted_d   = evicted_q;
        vc_addr_d   = vc_addr_q;
        pmem_addr_d = pmem_addr_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        case (state_q)
            IDLE: if (miss_req_i) begin
                state_d    = VC_REQ;
                vc_req_d   = 1'b1;
                vc_addr_d  = miss_addr_i;
                vc_dirty_d = evict_dirty_i;
                evicted_d  = evict_data_i;
            end
            VC_REQ: if (vc_resp_i) begin
                vc_req_d = 1'b0;
                if (vc_found_i) begin
                    state_d     = FILL;
                    miss_resp_d = 1'b1;
                    fill_d      = vc_dataout_i;
                    fill_vc_d   = 1'b1;
                    hit_d       = &hit_q ? hit_q : hit_q + CNT_W'(1);
                end else begin
                    state_d     = MEM_READ;
                    pmem_read_d = 1'b1;
                    pmem_addr_d = vc_addr_q & ~32'(WIDTH / 8 - 1);
                    miss_d      = &miss_q ? miss_q : miss_q + CNT_W'(1);
                end
            end
            MEM_READ: if (pmem_resp_i) begin
                state_d     = FILL;
                miss_resp_d = 1'b1;
                pmem_read_d = 1'b0;
                fill_d      = pmem_rdata_i;
                fill_vc_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            miss_resp_q <= 1'b0;
            fill_vc_q   <= 1'b0;
            vc_req_q    <= 1'b0;
            vc_dirty_q  <= 1'b0;
            pmem_read_q <= 1'b0;
            fill_q      <= '0;
            evicted_q   <= '0;
            vc_addr_q   <= '0;
            pmem_addr_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            miss_resp_q <= miss_resp_d;
            fill_vc_q   <= fill_vc_d;
            vc_req_q    <= vc_req_d;
            vc_dirty_q  <= vc_dirty_d;
            pmem_read_q <= pmem_read_d;
            fill_q      <= fill_d;
            evicted_q   <= evicted_d;
            vc_addr_q   <= vc_addr_d;
            pmem_addr_q <= pmem_addr_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign busy_o         = busy_q;
    assign miss_resp_o    = miss_resp_q;
    assign fill_data_o    = fill_q;
    assign fill_from_vc_o = fill_vc_q;
    assign vc_request_o   = vc_req_q;
    assign vc_address_o   = vc_addr_q;
    assign vc_is_dirty_o  = vc_dirty_q;
    assign vc_evicted_o   = evicted_q;
    assign pmem_read_o    = pmem_read_q;
    assign pmem_address_o = pmem_addr_q;
    assign vc_hit_cnt_o   = hit_q;
    assign vc_miss_cnt_o  = miss_q;
endmodule

// File: tb/tb_victim_swap_ctrl.sv
// tb_victim_swap_ctrl: directed vector table for the hit/miss paths plus hand-written
// sequences for stability, back-to-back, async reset abort and counter saturation.
module tb_victim_swap_ctrl;
    localparam int W  = 256;
    localparam int CW = 2;

    logic          clk = 0, rst_n = 0, miss_req = 0, evict_dirty = 0;
    logic          vc_resp = 0, vc_found = 0, pmem_resp = 0;
    logic [31:0]   miss_addr = 0;
    logic [W-1:0]  evict_data = 0, vc_dataout = 0, pmem_rdata = 0;
    logic          busy, miss_resp, fill_from_vc, vc_request, vc_is_dirty, pmem_read;
    logic [W-1:0]  fill_data, vc_evicted;
    logic [31:0]   vc_address, pmem_address;
    logic [CW-1:0] vc_hit_cnt, vc_miss_cnt;

    victim_swap_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .miss_req_i(miss_req), .miss_addr_i(miss_addr),
        .evict_dirty_i(evict_dirty), .evict_data_i(evict_data), .busy_o(busy),
        .miss_resp_o(miss_resp), .fill_data_o(fill_data), .fill_from_vc_o(fill_from_vc),
        .vc_request_o(vc_request), .vc_address_o(vc_address), .vc_is_dirty_o(vc_is_dirty),
        .vc_evicted_o(vc_evicted), .vc_resp_i(vc_resp), .vc_found_i(vc_found),
        .vc_dataout_i(vc_dataout), .pmem_read_o(pmem_read), .pmem_address_o(pmem_address),
        .pmem_rdata_i(pmem_rdata), .pmem_resp_i(pmem_resp), .vc_hit_cnt_o(vc_hit_cnt),
        .vc_miss_cnt_o(vc_miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         req;
        logic         resp;
        logic         found;
        logic         presp;
        logic         busy;
        logic         vreq;
        logic         pread;
        logic         mresp;
        logic         fvc;
        logic [1:0]   hit;
        logic [1:0]   miss;
        logic [31:0]  paddr;
        logic [W-1:0] fill;
    } vec_t;

    vec_t         tv[11];
    int           n_vec = 0, n_err = 0;
    logic [W-1:0] ha, h5, x3, p3, d4;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vc_hit(input logic [W-1:0] d, input int exp_hit);
        miss_req = 1;
        miss_addr = 32'h0000_0500;
        step();
        miss_req = 0;
        vc_resp = 1;
        vc_found = 1;
        vc_dataout = d;
        step();
        vc_resp = 0;
        chk("sat_mresp", miss_resp, 1);
        chk("sat_fill", fill_data, d);
        chk("sat_hit", vc_hit_cnt, exp_hit);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        ha = {32{8'hA5}};
        h5 = {32{8'h5A}};
        x3 = {8{32'hDEAD_BEEF}};
        p3 = {8{32'h1357_9BDF}};
        d4 = {8{32'hCAFE_F00D}};
        //        req rsp fnd prs busy vrq prd mrs fvc hit miss paddr          fill
        tv[0]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         '0};
        tv[1]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         '0};
        tv[2]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         '0};
        tv[3]  = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 32'h0,         ha};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0,         ha};
        tv[5]  = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 32'h0,         ha};
        tv[6]  = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 32'h0000_1220, ha};
        tv[7]  = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 32'h0000_1220, ha};
        tv[8]  = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 32'h0000_1220, h5};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_1220, h5};
        tv[10] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_1220, h5};

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_vreq", vc_request, 0);
        chk("rst_pread", pmem_read, 0);
        chk("rst_fill", fill_data, 0);
        chk("rst_hit", vc_hit_cnt, 0);
        #11 rst_n = 1;
        step();

        miss_addr  = 32'h0000_1234;
        vc_dataout = ha;
        pmem_rdata = h5;
        for (int i = 0; i < 11; i++) begin
            miss_req  = tv[i].req;
            vc_resp   = tv[i].resp;
            vc_found  = tv[i].found;
            pmem_resp = tv[i].presp;
            step();
            chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
            chk($sformatf("v%0d_vreq", i), vc_request, tv[i].vreq);
            chk($sformatf("v%0d_pread", i), pmem_read, tv[i].pread);
            chk($sformatf("v%0d_mresp", i), miss_resp, tv[i].mresp);
            chk($sformatf("v%0d_fvc", i), fill_from_vc, tv[i].fvc);
            chk($sformatf("v%0d_hit", i), vc_hit_cnt, tv[i].hit);
            chk($sformatf("v%0d_miss", i), vc_miss_cnt, tv[i].miss);
            chk($sformatf("v%0d_vaddr", i), vc_address, 32'h0000_1234);
            chk($sformatf("v%0d_paddr", i), pmem_address, tv[i].paddr);
            chk($sformatf("v%0d_fill", i), fill_data, tv[i].fill);
        end
        vc_resp = 0;
        vc_found = 0;
        pmem_resp = 0;

        // stability: captured request fields must not follow the inputs while busy
        miss_req = 1;
        miss_addr = 32'h0000_4000;
        evict_dirty = 1;
        evict_data = x3;
        step();
        for (int i = 0; i < 10; i++) begin
            miss_addr = 32'h0000_8000 + 32'(i * 256);
            evict_dirty = i[0];
            evict_data = ~x3 ^ W'(i);
            step();
            chk("stab_vaddr", vc_address, 32'h0000_4000);
            chk("stab_evict", vc_evicted, x3);
            chk("stab_dirty", vc_is_dirty, 1);
            chk("stab_vreq", vc_request, 1);
        end
        miss_req = 0;
        vc_resp = 1;
        vc_found = 0;
        step();
        vc_resp = 0;
        chk("stab_pread", pmem_read, 1);
        chk("stab_paddr", pmem_address, 32'h0000_4000);
        chk("stab_miss", vc_miss_cnt, 2);
        pmem_rdata = p3;
        pmem_resp = 1;
        step();
        pmem_resp = 0;
        chk("stab_mresp", miss_resp, 1);
        chk("stab_fill", fill_data, p3);
        chk("stab_fvc", fill_from_vc, 0);
        step();
        chk("stab_mresp_off", miss_resp, 0);
        step();
        chk("stab_idle", busy, 0);

        // back-to-back: request held across FILL is re-accepted after one idle cycle
        miss_req = 1;
        miss_addr = 32'h0000_0100;
        step();
        chk("b2b_vaddr1", vc_address, 32'h0000_0100);
        vc_resp = 1;
        vc_found = 1;
        vc_dataout = d4;
        step();
        vc_resp = 0;
        miss_addr = 32'h0000_0200;
        chk("b2b_mresp1", miss_resp, 1);
        chk("b2b_hit1", vc_hit_cnt, 2);
        step();
        chk("b2b_busy_gap", busy, 0);
        chk("b2b_mresp_gap", miss_resp, 0);
        step();
        miss_req = 0;
        chk("b2b_busy2", busy, 1);
        chk("b2b_vreq2", vc_request, 1);
        chk("b2b_vaddr2", vc_address, 32'h0000_0200);
        vc_resp = 1;
        step();
        vc_resp = 0;
        chk("b2b_mresp2", miss_resp, 1);
        chk("b2b_hit2", vc_hit_cnt, 3);
        step();
        chk("b2b_mresp_off", miss_resp, 0);
        step();
        chk("b2b_no_extra", miss_resp, 0);
        chk("b2b_idle", busy, 0);

        // async reset in MEM_READ aborts with no late fill
        miss_req = 1;
        miss_addr = 32'h0000_0300;
        step();
        miss_req = 0;
        vc_resp = 1;
        vc_found = 0;
        step();
        vc_resp = 0;
        chk("rstm_pread", pmem_read, 1);
        chk("rstm_miss_sat", vc_miss_cnt, 3);
        #2 rst_n = 0;
        #1;
        chk("rstm_pread0", pmem_read, 0);
        chk("rstm_busy0", busy, 0);
        chk("rstm_hit0", vc_hit_cnt, 0);
        chk("rstm_miss0", vc_miss_cnt, 0);
        chk("rstm_paddr0", pmem_address, 0);
        #2 rst_n = 1;
        pmem_resp = 1;
        step();
        pmem_resp = 0;
        chk("rstm_no_mresp", miss_resp, 0);
        chk("rstm_idle", busy, 0);
        step();
        chk("rstm_no_mresp2", miss_resp, 0);

        // saturation of a 2-bit hit counter
        for (int k = 1; k <= 5; k++)
            vc_hit({8{32'(k)}}, k > 3 ? 3 : k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
